// File: rtl/dmi_jtag_host.sv
// JTAG host: turns RESET / IR scan / DR scan / IDLE requests into TCK/TMS/TDI
// pulse trains, tracks the TAP in RunTestIdle between requests, captures TDO.
module dmi_jtag_host #(
  parameter int unsigned MaxLen = 64,
  parameter int unsigned ClkDiv = 2,
  parameter int unsigned LenW   = $clog2(MaxLen) + 1
) (
  input  logic              clk_i,
  input  logic              trst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [1:0]        req_op_i,
  input  logic [LenW-1:0]   req_len_i,
  input  logic [MaxLen-1:0] req_data_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [MaxLen-1:0] rsp_data_o,
  output logic              busy_o,
  output logic              tck_o,
  output logic              tms_o,
  output logic              tdi_o,
  input  logic              tdo_i,
  output logic              trst_no
);

  localparam int unsigned IdxW = (MaxLen > 1) ? $clog2(MaxLen) : 1;
  localparam int unsigned PhW  = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;

  typedef enum logic [1:0] {
    OP_RESET = 2'd0,
    OP_IR    = 2'd1,
    OP_DR    = 2'd2,
    OP_IDLE  = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_PREAMBLE,
    S_SHIFT,
    S_POSTAMBLE,
    S_RESP
  } state_e;

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [LenW-1:0]   len_q, len_d;
  logic [LenW-1:0]   pcnt_q, pcnt_d;
  logic [LenW-1:0]   bcnt_q, bcnt_d;
  logic [MaxLen-1:0] data_q, data_d;
  logic [MaxLen-1:0] rsp_q, rsp_d;
  logic [PhW-1:0]    ph_q, ph_d;
  logic              tck_q, tck_d;
  logic              tms_q, tms_d;
  logic              tdi_q, tdi_d;
  logic              trst_q;
  logic              start;
  logic [LenW-1:0]   len_in;
  logic [LenW-1:0]   pre_last;

  // TMS of the pulse described by (state, counters); evaluated for the next pulse.
  function automatic logic pulse_tms(input state_e st, input op_e op,
                                     input logic [LenW-1:0] pcnt,
                                     input logic [LenW-1:0] bcnt,
                                     input logic [LenW-1:0] len);
    logic t;
    t = 1'b0;
    case (st)
      S_INIT:      t = (pcnt < LenW'(5));
      S_PREAMBLE: begin
        case (op)
          OP_RESET: t = (pcnt < LenW'(5));
          OP_IR:    t = (pcnt < LenW'(2));
          OP_DR:    t = (pcnt == '0);
          default:  t = 1'b0;
        endcase
      end
      S_SHIFT:     t = (bcnt == len - LenW'(1));
      S_POSTAMBLE: t = (pcnt == '0);
      default:     t = 1'b0;
    endcase
    return t;
  endfunction

  always_comb begin
    len_in = req_len_i;
    if (req_len_i == '0) begin
      len_in = LenW'(1);
    end else if (req_len_i > LenW'(MaxLen)) begin
      len_in = LenW'(MaxLen);
    end
  end

  always_comb begin
    case (op_q)
      OP_RESET: pre_last = LenW'(5);
      OP_IR:    pre_last = LenW'(3);
      OP_DR:    pre_last = LenW'(2);
      default:  pre_last = len_q - LenW'(1);
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    len_d   = len_q;
    pcnt_d  = pcnt_q;
    bcnt_d  = bcnt_q;
    data_d  = data_q;
    rsp_d   = rsp_q;
    ph_d    = ph_q;
    tck_d   = tck_q;
    start   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          op_d    = op_e'(req_op_i);
          len_d   = len_in;
          data_d  = req_data_i;
          rsp_d   = '0;
          pcnt_d  = '0;
          bcnt_d  = '0;
          state_d = S_PREAMBLE;
          start   = 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        // A pulse is always in flight in the sequencing states.
        if (ph_q != PhW'(ClkDiv - 1)) begin
          ph_d = ph_q + 1'b1;
        end else begin
          ph_d = '0;
          if (!tck_q) begin
            tck_d = 1'b1;
            if (state_q == S_SHIFT) begin
              rsp_d[bcnt_q[IdxW-1:0]] = tdo_i;
            end
          end else begin
            tck_d = 1'b0;
            case (state_q)
              S_INIT: begin
                if (pcnt_q == LenW'(5)) begin
                  state_d = S_IDLE;
                end else begin
                  pcnt_d = pcnt_q + 1'b1;
                  start  = 1'b1;
                end
              end
              S_PREAMBLE: begin
                if (pcnt_q == pre_last) begin
                  if (op_q == OP_IR || op_q == OP_DR) begin
                    state_d = S_SHIFT;
                    bcnt_d  = '0;
                    start   = 1'b1;
                  end else begin
                    state_d = S_RESP;
                  end
                end else begin
                  pcnt_d = pcnt_q + 1'b1;
                  start  = 1'b1;
                end
              end
              S_SHIFT: begin
                if (bcnt_q == len_q - LenW'(1)) begin
                  state_d = S_POSTAMBLE;
                  pcnt_d  = '0;
                end else begin
                  bcnt_d = bcnt_q + 1'b1;
                end
                start = 1'b1;
              end
              S_POSTAMBLE: begin
                if (pcnt_q == LenW'(1)) begin
                  state_d = S_RESP;
                end else begin
                  pcnt_d = pcnt_q + 1'b1;
                  start  = 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
      end
    endcase

    if (start) begin
      ph_d  = '0;
      tck_d = 1'b0;
    end
    tms_d = start ? pulse_tms(state_d, op_d, pcnt_d, bcnt_d, len_d) : tms_q;
    tdi_d = start ? ((state_d == S_SHIFT) && data_d[bcnt_d[IdxW-1:0]]) : tdi_q;
  end

  // Reset places the host in the low phase of the first init pulse.
  always_ff @(posedge clk_i or negedge trst_ni) begin
    if (!trst_ni) begin
      state_q <= S_INIT;
      op_q    <= OP_RESET;
      len_q   <= '0;
      pcnt_q  <= '0;
      bcnt_q  <= '0;
      data_q  <= '0;
      rsp_q   <= '0;
      ph_q    <= '0;
      tck_q   <= 1'b0;
      tms_q   <= 1'b1;
      tdi_q   <= 1'b0;
      trst_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      len_q   <= len_d;
      pcnt_q  <= pcnt_d;
      bcnt_q  <= bcnt_d;
      data_q  <= data_d;
      rsp_q   <= rsp_d;
      ph_q    <= ph_d;
      tck_q   <= tck_d;
      tms_q   <= tms_d;
      tdi_q   <= tdi_d;
      trst_q  <= 1'b1;
    end
  end

  assign req_ready_o = (state_q == S_IDLE);
  assign rsp_valid_o = (state_q == S_RESP);
  assign busy_o      = (state_q != S_IDLE) && (state_q != S_RESP);
  assign rsp_data_o  = rsp_q;
  assign tck_o       = tck_q;
  assign tms_o       = tms_q;
  assign tdi_o       = tdi_q;
  assign trst_no     = trst_q;

endmodule

// File: tb/tb_dmi_jtag_host.sv
// Directed bench for dmi_jtag_host against a behavioural TAP (IR length 5).
module tb_dmi_jtag_host;

  localparam int unsigned MaxLen = 64;
  localparam int unsigned ClkDiv = 2;
  localparam int unsigned LenW   = 7;
  localparam logic [4:0]  IrIdcode = 5'h01;

  logic              clk_i       = 1'b0;
  logic              trst_ni     = 1'b0;
  logic              req_valid_i = 1'b0;
  logic [1:0]        req_op_i    = '0;
  logic [LenW-1:0]   req_len_i   = '0;
  logic [MaxLen-1:0] req_data_i  = '0;
  logic              rsp_ready_i = 1'b0;
  logic              req_ready_o, rsp_valid_o, busy_o, tck_o, tms_o, tdi_o, trst_no;
  logic [MaxLen-1:0] rsp_data_o;
  logic              tdo_m;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk_i = ~clk_i;

  dmi_jtag_host #(.MaxLen(MaxLen), .ClkDiv(ClkDiv)) dut (
    .clk_i(clk_i), .trst_ni(trst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_op_i(req_op_i), .req_len_i(req_len_i), .req_data_i(req_data_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
    .busy_o(busy_o), .tck_o(tck_o), .tms_o(tms_o), .tdi_o(tdi_o),
    .tdo_i(tdo_m), .trst_no(trst_no)
  );

  // Pulse and response monitors
  int          pulse_cnt = 0;
  logic [63:0] tms_hist  = '0;
  int          rise_cnt  = 0;
  logic        rv_prev   = 1'b0;

  always @(posedge tck_o) begin
    pulse_cnt <= pulse_cnt + 1;
    tms_hist  <= {tms_hist[62:0], tms_o};
  end

  always @(posedge clk_i) begin
    rv_prev <= rsp_valid_o;
    if (rsp_valid_o && !rv_prev) rise_cnt <= rise_cnt + 1;
  end

  // Behavioural TAP: IDCODE = 1, every other instruction selects a 1-bit bypass.
  typedef enum logic [3:0] {
    TLR, RTI, SDR, CDR, SHDR, E1DR, PDR, E2DR, UDR,
    SIR, CIR, SHIR, E1IR, PIR, E2IR, UIR
  } tap_e;

  tap_e        ts;
  logic [4:0]  ir_m, ir_sr;
  logic [31:0] dr_sr;

  function automatic tap_e tap_next(input tap_e s, input logic t);
    case (s)
      TLR:  return t ? TLR  : RTI;
      RTI:  return t ? SDR  : RTI;
      SDR:  return t ? SIR  : CDR;
      CDR:  return t ? E1DR : SHDR;
      SHDR: return t ? E1DR : SHDR;
      E1DR: return t ? UDR  : PDR;
      PDR:  return t ? E2DR : PDR;
      E2DR: return t ? UDR  : SHDR;
      UDR:  return t ? SDR  : RTI;
      SIR:  return t ? TLR  : CIR;
      CIR:  return t ? E1IR : SHIR;
      SHIR: return t ? E1IR : SHIR;
      E1IR: return t ? UIR  : PIR;
      PIR:  return t ? E2IR : PIR;
      E2IR: return t ? UIR  : SHIR;
      default: return t ? SDR : RTI;
    endcase
  endfunction

  always @(posedge tck_o or negedge trst_no) begin
    if (!trst_no) begin
      ts    <= TLR;
      ir_m  <= IrIdcode;
      ir_sr <= '0;
      dr_sr <= '0;
    end else begin
      ts <= tap_next(ts, tms_o);
      if (ts == TLR)  ir_m  <= IrIdcode;
      if (ts == CIR)  ir_sr <= 5'h05;
      if (ts == SHIR) ir_sr <= {tdi_o, ir_sr[4:1]};
      if (ts == UIR)  ir_m  <= ir_sr;
      if (ts == CDR)  dr_sr <= (ir_m == IrIdcode) ? 32'h1 : 32'h0;
      if (ts == SHDR) dr_sr <= (ir_m == IrIdcode) ? {tdi_o, dr_sr[31:1]} : {31'b0, tdi_o};
    end
  end

  always @(negedge tck_o or negedge trst_no) begin
    if (!trst_no) tdo_m <= 1'b0;
    else if (ts == SHDR) tdo_m <= dr_sr[0];
    else if (ts == SHIR) tdo_m <= ir_sr[0];
    else tdo_m <= 1'b0;
  end

  // Issue one request and wait for its response (left pending).
  task automatic run_op(input logic [1:0] op, input logic [LenW-1:0] len,
                        input logic [MaxLen-1:0] data,
                        output logic [MaxLen-1:0] rsp, output int pulses, output int lat);
    int n, p0;
    n = 0;
    while (!req_ready_o && n < 1000) begin
      @(posedge clk_i); #1; n++;
    end
    if (!req_ready_o) begin
      n_cmp++; n_fail++;
      $display("FAIL req_ready_timeout: got 0 want 1");
    end
    @(negedge clk_i);
    req_valid_i = 1'b1; req_op_i = op; req_len_i = len; req_data_i = data;
    p0 = pulse_cnt;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    lat = 0;
    while (!rsp_valid_o && lat < 2000) begin
      @(posedge clk_i); #1; lat++;
    end
    if (!rsp_valid_o) begin
      n_cmp++; n_fail++;
      $display("FAIL rsp_valid_timeout: got 0 want 1");
    end
    pulses = pulse_cnt - p0;
    rsp    = rsp_data_o;
  endtask

  task automatic finish_rsp();
    @(negedge clk_i); rsp_ready_i = 1'b1;
    @(posedge clk_i); #1; rsp_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    trst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    n_cmp++; if (tck_o !== 1'b0)       begin n_fail++; $display("FAIL reset_tck: got %b want 0", tck_o); end
    n_cmp++; if (tms_o !== 1'b1)       begin n_fail++; $display("FAIL reset_tms: got %b want 1", tms_o); end
    n_cmp++; if (tdi_o !== 1'b0)       begin n_fail++; $display("FAIL reset_tdi: got %b want 0", tdi_o); end
    n_cmp++; if (req_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready: got %b want 0", req_ready_o); end
    n_cmp++; if (rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid_o); end
    n_cmp++; if (rsp_data_o !== '0)    begin n_fail++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data_o); end
    n_cmp++; if (busy_o !== 1'b1)      begin n_fail++; $display("FAIL reset_busy: got %b want 1", busy_o); end
    n_cmp++; if (trst_no !== 1'b0)     begin n_fail++; $display("FAIL reset_trst_no: got %b want 0", trst_no); end
  endtask

  task automatic test_init();
    int p0, cyc;
    @(negedge clk_i);
    p0 = pulse_cnt;
    trst_ni = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk_i); #1; cyc++;
    end while (!req_ready_o && cyc < 200);
    n_cmp++; if (cyc != 24)            begin n_fail++; $display("FAIL init_cycles: got %0d want 24", cyc); end
    n_cmp++; if (pulse_cnt - p0 != 6)  begin n_fail++; $display("FAIL init_pulses: got %0d want 6", pulse_cnt - p0); end
    n_cmp++; if (tms_hist[5:0] !== 6'b111110) begin n_fail++; $display("FAIL init_tms: got %b want 111110", tms_hist[5:0]); end
    n_cmp++; if (busy_o !== 1'b0)      begin n_fail++; $display("FAIL init_busy: got %b want 0", busy_o); end
    n_cmp++; if (trst_no !== 1'b1)     begin n_fail++; $display("FAIL init_trst_no: got %b want 1", trst_no); end
    n_cmp++; if (ts != RTI)            begin n_fail++; $display("FAIL init_tap_state: got %0d want %0d", ts, RTI); end
  endtask

  task automatic test_ir_scan();
    logic [MaxLen-1:0] rsp; int pulses, lat;
    run_op(2'd1, 7'd5, 64'h11, rsp, pulses, lat);
    n_cmp++; if (pulses != 11)         begin n_fail++; $display("FAIL ir_pulses: got %0d want 11", pulses); end
    n_cmp++; if (tms_hist[10:0] !== 11'b11000000110) begin n_fail++; $display("FAIL ir_tms: got %b want 11000000110", tms_hist[10:0]); end
    n_cmp++; if (rsp !== 64'h05)       begin n_fail++; $display("FAIL ir_rsp: got %h want 5", rsp); end
    n_cmp++; if (ir_m !== 5'h11)       begin n_fail++; $display("FAIL ir_tap_ir: got %h want 11", ir_m); end
    n_cmp++; if (lat != 44)            begin n_fail++; $display("FAIL ir_latency: got %0d want 44", lat); end
    n_cmp++; if (busy_o !== 1'b0 || tck_o !== 1'b0) begin n_fail++; $display("FAIL ir_rsp_state: busy %b tck %b want 0 0", busy_o, tck_o); end
    finish_rsp();
  endtask

  task automatic test_idcode();
    logic [MaxLen-1:0] rsp; int pulses, lat;
    run_op(2'd0, 7'd0, 64'hFFFF, rsp, pulses, lat);
    n_cmp++; if (pulses != 6)          begin n_fail++; $display("FAIL rst_pulses: got %0d want 6", pulses); end
    n_cmp++; if (tms_hist[5:0] !== 6'b111110) begin n_fail++; $display("FAIL rst_tms: got %b want 111110", tms_hist[5:0]); end
    n_cmp++; if (rsp !== '0)           begin n_fail++; $display("FAIL rst_rsp: got %h want 0", rsp); end
    n_cmp++; if (ir_m !== IrIdcode)    begin n_fail++; $display("FAIL rst_tap_ir: got %h want %h", ir_m, IrIdcode); end
    finish_rsp();
    run_op(2'd2, 7'd32, 64'h0, rsp, pulses, lat);
    n_cmp++; if (pulses != 37)         begin n_fail++; $display("FAIL idcode_pulses: got %0d want 37", pulses); end
    n_cmp++; if (rsp !== 64'h1)        begin n_fail++; $display("FAIL idcode_rsp: got %h want 1", rsp); end
    n_cmp++; if (lat != 148)           begin n_fail++; $display("FAIL idcode_latency: got %0d want 148", lat); end
    finish_rsp();
  endtask

  task automatic test_bypass();
    logic [MaxLen-1:0] rsp; int pulses, lat;
    run_op(2'd1, 7'd5, 64'h1f, rsp, pulses, lat);
    n_cmp++; if (ir_m !== 5'h1f)       begin n_fail++; $display("FAIL byp_tap_ir: got %h want 1f", ir_m); end
    finish_rsp();
    run_op(2'd2, 7'd8, 64'hA5, rsp, pulses, lat);
    n_cmp++; if (rsp !== 64'h4A)       begin n_fail++; $display("FAIL byp_rsp: got %h want 4a", rsp); end
    n_cmp++; if (pulses != 13)         begin n_fail++; $display("FAIL byp_pulses: got %0d want 13", pulses); end
    finish_rsp();
  endtask

  task automatic test_backpressure();
    logic [MaxLen-1:0] rsp; int pulses, lat;
    run_op(2'd2, 7'd8, 64'hA5, rsp, pulses, lat);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_i); #1;
      n_cmp++;
      if (rsp_valid_o !== 1'b1 || rsp_data_o !== 64'h4A || tck_o !== 1'b0 || req_ready_o !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: valid %b data %h tck %b ready %b want 1 4a 0 0",
                 i, rsp_valid_o, rsp_data_o, tck_o, req_ready_o);
      end
    end
    finish_rsp();
    n_cmp++; if (req_ready_o !== 1'b1 || rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL bp_release: ready %b valid %b want 1 0", req_ready_o, rsp_valid_o); end
  endtask

  task automatic test_idle_len();
    logic [MaxLen-1:0] rsp; int pulses, lat;
    run_op(2'd3, 7'd0, '1, rsp, pulses, lat);
    n_cmp++; if (pulses != 1)          begin n_fail++; $display("FAIL idle0_pulses: got %0d want 1", pulses); end
    n_cmp++; if (rsp !== '0)           begin n_fail++; $display("FAIL idle0_rsp: got %h want 0", rsp); end
    n_cmp++; if (lat != 4)             begin n_fail++; $display("FAIL idle0_latency: got %0d want 4", lat); end
    finish_rsp();
    run_op(2'd3, 7'd100, '0, rsp, pulses, lat);
    n_cmp++; if (pulses != 64)         begin n_fail++; $display("FAIL idle_sat_pulses: got %0d want 64", pulses); end
    n_cmp++; if (lat != 256)           begin n_fail++; $display("FAIL idle_sat_latency: got %0d want 256", lat); end
    finish_rsp();
  endtask

  task automatic test_reset_mid_scan();
    int n, p0, r0;
    n = 0;
    while (!req_ready_o && n < 1000) begin
      @(posedge clk_i); #1; n++;
    end
    @(negedge clk_i);
    req_valid_i = 1'b1; req_op_i = 2'd2; req_len_i = 7'd32; req_data_i = 64'hFFFF_FFFF;
    p0 = pulse_cnt;
    r0 = rise_cnt;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    n = 0;
    while (pulse_cnt - p0 < 14 && n < 500) begin
      @(posedge clk_i); #1; n++;
    end
    n_cmp++; if (pulse_cnt - p0 < 14)  begin n_fail++; $display("FAIL mid_progress: got %0d pulses want 14", pulse_cnt - p0); end
    @(negedge clk_i);
    trst_ni = 1'b0;
    #1;
    n_cmp++; if (tck_o !== 1'b0 || tms_o !== 1'b1) begin n_fail++; $display("FAIL mid_reset_pins: tck %b tms %b want 0 1", tck_o, tms_o); end
    n_cmp++; if (rsp_valid_o !== 1'b0 || busy_o !== 1'b1 || req_ready_o !== 1'b0) begin n_fail++; $display("FAIL mid_reset_flags: valid %b busy %b ready %b want 0 1 0", rsp_valid_o, busy_o, req_ready_o); end
    n_cmp++; if (trst_no !== 1'b0)     begin n_fail++; $display("FAIL mid_reset_trst_no: got %b want 0", trst_no); end
    repeat (3) @(posedge clk_i);
    test_init();
    n_cmp++; if (rise_cnt != r0)       begin n_fail++; $display("FAIL mid_no_rsp: got %0d responses want 0", rise_cnt - r0); end
  endtask

  initial begin
    test_reset();
    test_init();
    test_ir_scan();
    test_idcode();
    test_bypass();
    test_backpressure();
    test_idle_len();
    test_reset_mid_scan();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
